// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Lets two requesters share one external combinational ALU, one operation
//   at a time. A round-robin arbiter picks between the requesters. A
//   three-state FSM (IDLE -> EXEC -> RESP) then takes the winner's operation,
//   drives it to the ALU, registers the result and flags, and holds a tagged
//   response until the consumer accepts it.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid / reqN_ready          request handshake for requester N (0, 1)
//   reqN_a, reqN_b, reqN_cin,
//   reqN_mode                        operation of requester N
//   alu_a, alu_b, alu_cin, alu_mode  latched operation sent to the ALU
//   alu_result, alu_flags            ALU outputs, flags = {c, v, z, n}
//   resp_valid / resp_ready          response handshake
//   resp_id, resp_result, resp_flags tagged, registered response
//   busy                             high while state is not IDLE
module alu_rr_scheduler #(
    parameter int W      = 8,
    parameter int MODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [W-1:0]      req0_a,
    input  logic [W-1:0]      req0_b,
    input  logic              req0_cin,
    input  logic [MODE_W-1:0] req0_mode,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [W-1:0]      req1_a,
    input  logic [W-1:0]      req1_b,
    input  logic              req1_cin,
    input  logic [MODE_W-1:0] req1_mode,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic              alu_cin,
    output logic [MODE_W-1:0] alu_mode,
    input  logic [W-1:0]      alu_result,
    input  logic [3:0]        alu_flags,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_id,
    output logic [W-1:0]      resp_result,
    output logic [3:0]        resp_flags,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q;
    logic                last_grant_q;
    logic                id_q;
    logic [W-1:0]        a_q, b_q;
    logic                cin_q;
    logic [MODE_W-1:0]   mode_q;
    logic                resp_valid_q, resp_id_q, busy_q;
    logic [W-1:0]        resp_result_q;
    logic [3:0]          resp_flags_q;

    logic                grant_d;
    logic                accept_d;
    logic                can_accept;

    // On a tie the requester that did not win last time goes first. With one
    // valid requester, that requester wins.
    always_comb begin
        grant_d = 1'b0;
        if (req0_valid && req1_valid)
            grant_d = ~last_grant_q;
        else if (req1_valid)
            grant_d = 1'b1;
    end

    // rst blocks the readys so that reset wins over a request in the same cycle.
    assign can_accept = (state_q == IDLE) && !rst;
    assign req0_ready = can_accept && req0_valid && !grant_d;
    assign req1_ready = can_accept && req1_valid &&  grant_d;
    assign accept_d   = req0_ready || req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            id_q          <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
            mode_q        <= '0;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_flags_q  <= '0;
            busy_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        a_q          <= grant_d ? req1_a    : req0_a;
                        b_q          <= grant_d ? req1_b    : req0_b;
                        cin_q        <= grant_d ? req1_cin  : req0_cin;
                        mode_q       <= grant_d ? req1_mode : req0_mode;
                        id_q         <= grant_d;
                        last_grant_q <= grant_d;
                        busy_q       <= 1'b1;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    // The ALU is combinational, so its outputs are valid after
                    // one cycle with the latched operands applied.
                    resp_result_q <= alu_result;
                    resp_flags_q  <= alu_flags;
                    resp_id_q     <= id_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_cin     = cin_q;
    assign alu_mode    = mode_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_flags  = resp_flags_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Testbench for alu_rr_scheduler. A small reference ALU (add, sub, xor,
// default and) stands in for the external ALU. A per-cycle vector table covers
// the single request, the round-robin tie and the zero-flag cases. Hand-written
// sequences cover backpressure, reset mid-operation and idle stability.
module tb_alu_rr_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_ready, req0_cin;
    logic [7:0] req0_a, req0_b;
    logic [3:0] req0_mode;
    logic       req1_valid, req1_ready, req1_cin;
    logic [7:0] req1_a, req1_b;
    logic [3:0] req1_mode;
    logic [7:0] alu_a, alu_b, alu_result;
    logic       alu_cin;
    logic [3:0] alu_mode, alu_flags;
    logic       resp_valid, resp_ready, resp_id, busy;
    logic [7:0] resp_result;
    logic [3:0] resp_flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_rr_scheduler #(.W(8), .MODE_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_cin(req0_cin), .req0_mode(req0_mode),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_cin(req1_cin), .req1_mode(req1_mode),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_flags(resp_flags), .busy(busy)
    );

    // Reference ALU, flags = {carry/borrow, overflow, zero, negative}
    always_comb begin
        logic [8:0] t;
        logic       c, v;
        t = 9'd0; c = 1'b0; v = 1'b0;
        case (alu_mode)
            4'd0: begin
                t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
                c = t[8];
                v = (alu_a[7] == alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'd1: begin
                t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
                c = t[8];
                v = (alu_a[7] != alu_b[7]) && (t[7] != alu_a[7]);
            end
            4'd6:    t = {1'b0, alu_a ^ alu_b};
            default: t = {1'b0, alu_a & alu_b};
        endcase
        alu_result = t[7:0];
        alu_flags  = {c, v, (t[7:0] == 8'd0), t[7]};
    end

    typedef struct {
        logic       rs, v0, v1;
        logic [7:0] a0, b0;
        logic [3:0] m0;
        logic [7:0] a1, b1;
        logic [3:0] m1;
        logic       rr;
        logic       er0, er1, ebusy, erv, erid;
        logic [7:0] eres;
        logic [3:0] eflg;
        logic [7:0] ealua;
    } vec_t;

    function automatic vec_t mk(input logic rs, v0, v1, input logic [7:0] a0, b0,
                                input logic [3:0] m0, input logic [7:0] a1, b1,
                                input logic [3:0] m1, input logic rr, er0, er1,
                                ebusy, erv, erid, input logic [7:0] eres,
                                input logic [3:0] eflg, input logic [7:0] ealua);
        vec_t x;
        x.rs = rs; x.v0 = v0; x.v1 = v1; x.a0 = a0; x.b0 = b0; x.m0 = m0;
        x.a1 = a1; x.b1 = b1; x.m1 = m1; x.rr = rr; x.er0 = er0; x.er1 = er1;
        x.ebusy = ebusy; x.erv = erv; x.erid = erid; x.eres = eres;
        x.eflg = eflg; x.ealua = ealua;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t x);
        rst = x.rs; resp_ready = x.rr;
        req0_valid = x.v0; req0_a = x.a0; req0_b = x.b0; req0_mode = x.m0; req0_cin = 1'b0;
        req1_valid = x.v1; req1_a = x.a1; req1_b = x.b1; req1_mode = x.m1; req1_cin = 1'b0;
    endtask

    vec_t tbl[20];

    initial begin
        // Both requesters valid: 0 = add 7F+01, 1 = sub 00-01
        tbl[0]  = mk(0,1,0, 8'h7F,8'h01,4'd0, 8'h00,8'h00,4'd0, 1, 1,0,0,0,0, 8'h00,4'h0, 8'h00);
        tbl[1]  = mk(0,0,0, 8'h7F,8'h01,4'd0, 8'h00,8'h00,4'd0, 1, 0,0,1,0,0, 8'h00,4'h0, 8'h7F);
        tbl[2]  = mk(0,0,0, 8'h7F,8'h01,4'd0, 8'h00,8'h00,4'd0, 1, 0,0,1,1,0, 8'h80,4'h5, 8'h7F);
        tbl[3]  = mk(1,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,0,0,0, 8'h00,4'h0, 8'h7F);
        tbl[4]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 1,0,0,0,0, 8'h00,4'h0, 8'h00);
        tbl[5]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,0,0, 8'h00,4'h0, 8'h7F);
        tbl[6]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,1,0, 8'h80,4'h5, 8'h7F);
        tbl[7]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,1,0,0,0, 8'h00,4'h0, 8'h7F);
        tbl[8]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,0,0, 8'h00,4'h0, 8'h00);
        tbl[9]  = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,1,1, 8'hFF,4'h9, 8'h00);
        tbl[10] = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 1,0,0,0,0, 8'h00,4'h0, 8'h00);
        tbl[11] = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,0,0, 8'h00,4'h0, 8'h7F);
        tbl[12] = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,1,0, 8'h80,4'h5, 8'h7F);
        tbl[13] = mk(0,1,1, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,1,0,0,0, 8'h00,4'h0, 8'h7F);
        tbl[14] = mk(0,0,0, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,0,0, 8'h00,4'h0, 8'h00);
        tbl[15] = mk(0,0,0, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 1, 0,0,1,1,1, 8'hFF,4'h9, 8'h00);
        // Zero flag: requester 1 XOR FF^FF
        tbl[16] = mk(0,0,1, 8'h00,8'h00,4'd0, 8'hFF,8'hFF,4'd6, 1, 0,1,0,0,0, 8'h00,4'h0, 8'h00);
        tbl[17] = mk(0,0,0, 8'h00,8'h00,4'd0, 8'hFF,8'hFF,4'd6, 1, 0,0,1,0,0, 8'h00,4'h0, 8'hFF);
        tbl[18] = mk(0,0,0, 8'h00,8'h00,4'd0, 8'hFF,8'hFF,4'd6, 1, 0,0,1,1,1, 8'h00,4'h2, 8'hFF);
        tbl[19] = mk(0,0,0, 8'h00,8'h00,4'd0, 8'h00,8'h00,4'd0, 1, 0,0,0,0,0, 8'h00,4'h0, 8'hFF);

        // Reset with requests pending: reset wins and everything clears.
        apply(mk(1,1,1, 8'h12,8'h34,4'd0, 8'h56,8'h78,4'd0, 0, 0,0,0,0,0, 8'h00,4'h0, 8'h00));
        cyc(); cyc();
        #1;
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rid", resp_id, 0);
        chk("rst_result", resp_result, 0);
        chk("rst_flags", resp_flags, 0);
        chk("rst_alu", {alu_a, alu_b, alu_cin, alu_mode}, 0);

        foreach (tbl[i]) begin
            if (i != 0) cyc();
            apply(tbl[i]);
            #1;
            chk($sformatf("v%0d_ready0", i), req0_ready, tbl[i].er0);
            chk($sformatf("v%0d_ready1", i), req1_ready, tbl[i].er1);
            chk($sformatf("v%0d_busy", i), busy, tbl[i].ebusy);
            chk($sformatf("v%0d_rvalid", i), resp_valid, tbl[i].erv);
            chk($sformatf("v%0d_alu_a", i), alu_a, tbl[i].ealua);
            if (tbl[i].erv) begin
                chk($sformatf("v%0d_rid", i), resp_id, tbl[i].erid);
                chk($sformatf("v%0d_result", i), resp_result, tbl[i].eres);
                chk($sformatf("v%0d_flags", i), resp_flags, tbl[i].eflg);
            end
        end

        // Backpressure: req0 adds 7F+01, then the response is held 5 cycles
        // while req1 waits.
        cyc();
        apply(mk(0,1,0, 8'h7F,8'h01,4'd0, 8'h00,8'h01,4'd1, 0, 0,0,0,0,0, 8'h00,4'h0, 8'h00));
        #1; chk("bp_accept0", req0_ready, 1);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b1;  // EXEC
        #1; chk("bp_exec_ready1", req1_ready, 0);
        for (int k = 0; k < 5; k++) begin
            cyc(); #1;
            chk($sformatf("bp%0d_rvalid", k), resp_valid, 1);
            chk($sformatf("bp%0d_rid", k), resp_id, 0);
            chk($sformatf("bp%0d_result", k), resp_result, 8'h80);
            chk($sformatf("bp%0d_ready1", k), req1_ready, 0);
        end
        cyc(); resp_ready = 1'b1;
        #1;
        chk("bp_hs_rvalid", resp_valid, 1);
        chk("bp_hs_ready1", req1_ready, 0);
        cyc(); #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_rvalid", resp_valid, 0);
        chk("bp_idle_ready1", req1_ready, 1);
        cyc(); req1_valid = 1'b0;
        cyc(); #1;
        chk("bp_r1_rid", resp_id, 1);
        chk("bp_r1_result", resp_result, 8'hFF);
        chk("bp_r1_flags", resp_flags, 4'h9);

        // Reset during EXEC discards the operation and re-arms the tie-break.
        cyc(); req0_valid = 1'b1;  // IDLE: req0 accepted
        #1; chk("mr_accept0", req0_ready, 1);
        cyc(); req0_valid = 1'b0; rst = 1'b1;  // EXEC
        #1; chk("mr_exec_busy", busy, 1);
        cyc(); rst = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_rvalid", resp_valid, 0);
        cyc(); #1;
        chk("mr_rvalid2", resp_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 8'h10; req0_b = 8'h05; req0_cin = 1'b1; req0_mode = 4'd0;
        #1;
        chk("mr_tie_ready0", req0_ready, 1);
        chk("mr_tie_ready1", req1_ready, 0);
        cyc(); req0_valid = 1'b0; req1_valid = 1'b0;
        cyc(); #1;
        chk("mr_result", resp_result, 8'h16);
        chk("mr_flags", resp_flags, 4'h0);
        chk("mr_rid", resp_id, 0);

        // Idle stability: 10 cycles with no requests.
        for (int k = 0; k < 10; k++) begin
            cyc(); #1;
            chk($sformatf("idle%0d_busy", k), busy, 0);
            chk($sformatf("idle%0d_ready", k), {req0_ready, req1_ready}, 0);
            chk($sformatf("idle%0d_rvalid", k), resp_valid, 0);
            chk($sformatf("idle%0d_alu", k), {alu_a, alu_b, alu_cin, alu_mode},
                {8'h10, 8'h05, 1'b1, 4'd0});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
Shares one combinational 8-bit ALU (16 modes, flags carry/overflow/zero/negative) between two requesters. The requesters are typically a sequencer and a debug/test port. A two-requester round-robin arbiter feeds a three-state FSM that:
- accepts one operation,
- drives it to the ALU and registers the result and flags,
- holds a tagged response until the consumer accepts it.
The ALU itself sits outside the block and connects through the alu_* ports.

Parameters:
- W, 8, operand/result width; must match the ALU.
- MODE_W, 4, ALU mode width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  W  operand A.
- req0_b  in  W  operand B.
- req0_cin  in  1  carry/borrow in.
- req0_mode  in  MODE_W  ALU mode.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin, req1_mode: same as requester 0, for requester 1.
- alu_a  out  W  latched operand A to the ALU.
- alu_b  out  W  latched operand B to the ALU.
- alu_cin  out  1  latched carry-in to the ALU.
- alu_mode  out  MODE_W  latched mode to the ALU.
- alu_result  in  W  ALU result.
- alu_flags  in  4  ALU flags, packed {carry, overflow, zero, negative}.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  1  requester that issued the operation.
- resp_result  out  W  registered result.
- resp_flags  out  4  registered flags, same packing as alu_flags.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - All latched operand, result and flag registers = 0.
  - resp_valid=0, resp_id=0, busy=0.
  - req0_ready and req1_ready are 0 while rst is high.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: (state==IDLE) & reqN_valid & grant==N. At most one ready is high.
  - Grant, one requester valid: that requester wins.
  - Grant, both valid: the requester that is not last_grant wins.
  - Grant, none valid: no ready; stay in IDLE.
  - On accept (valid & ready): latch a, b, cin, mode and the id; set last_grant=id; go to EXEC.
- EXEC (exactly one cycle):
  - alu_* outputs are driven from the latched registers. They are constant outside EXEC as well and change only on accept.
  - At the end of the cycle: resp_result<=alu_result, resp_flags<=alu_flags, resp_id<=latched id; go to RESP.
- RESP:
  - resp_valid=1. resp_id, resp_result and resp_flags are held stable until resp_valid & resp_ready.
  - On that handshake: resp_valid drops on the next cycle and the FSM returns to IDLE.
  - No new request is accepted in RESP, including in the cycle resp_ready is seen.
- Latency and throughput:
  - Accept at cycle T gives resp_valid at T+2.
  - With resp_ready held high, one operation completes every 3 cycles.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1,… No requester waits more than one operation.
- Request stability: a requester must hold valid and its operands until ready. The block does not check this; operands are sampled only in the accept cycle.
- No width extension: the block passes the ALU result and flags through unchanged. Mode decoding and flag semantics belong to the ALU.
- Reset mid-operation (rst in EXEC or RESP): the in-flight operation and response are discarded. No resp_valid is produced for it, and the state returns to IDLE next cycle.
- Reset and request in the same cycle: reset wins; no accept.

Test Plan:
1. Single request:
   - Stimulus: after reset, req0_valid=1, a=0x7F, b=0x01, cin=0, mode=0000.
   - Response: req0_ready=1 at T; alu_a=0x7F at T+1; resp_valid=1 at T+2 with resp_id=0, resp_result=0x80, resp_flags=4'b0101 (overflow, negative).
2. Round-robin tie:
   - Stimulus: req0 and req1 valid continuously; req1 a=0x00, b=0x01, mode=0001; resp_ready=1.
   - Response: accept order 0,1,0,1. Each req1 response is resp_result=0xFF, resp_flags=4'b1001 (carry/borrow, negative).
3. Response backpressure:
   - Stimulus: resp_ready=0 for 5 cycles in RESP, with req1_valid=1 throughout.
   - Response: resp_valid, resp_id and resp_result stay constant; req1_ready stays 0. When resp_ready=1: IDLE next cycle, then req1 is accepted.
4. Zero flag path:
   - Stimulus: req1 a=0xFF, b=0xFF, mode=0110 (XOR).
   - Response: resp_result=0x00, resp_flags=4'b0010, resp_id=1.
5. Reset mid-operation:
   - Stimulus: assert rst for one cycle while in EXEC.
   - Response: no resp_valid afterwards; busy=0 next cycle. The next simultaneous request pair grants requester 0 first.
6. Idle stability:
   - Stimulus: no valid for 10 cycles.
   - Response: busy=0, both readys 0, resp_valid 0, alu_* unchanged.
